// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared definitions for the memory arbiter slice: arbiter state encodings
// and the single-bit command/handshake constants used by the arbiter RTL.
// No ports (package only).
package mem_arbiter_pkg;

  // Arbiter state bus and its encodings.
  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ArbIdle  = 2'd0;
  localparam arb_state_t ArbBusyI = 2'd1;
  localparam arb_state_t ArbBusyL = 2'd2;
  localparam arb_state_t ArbDrain = 2'd3;

  // Handshake and direction constants.
  localparam logic Valid   = 1'b1;
  localparam logic Invalid = 1'b0;
  localparam logic Read    = 1'b0;
  localparam logic Write   = 1'b1;

endpackage

// File: rtl/mem_arbiter_starve.sv
// mem_arbiter_starve
// Starvation guard for the memory arbiter. Counts consecutive LSB grants
// taken while a fetch is waiting and forces the fetch once the count reaches
// STARVE_LIMIT. Only instantiated when MEM_ARB_STARVE_GUARD_EN is defined.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   rdy          global ready; low freezes the counter
//   ic_req       fetch request currently pending
//   grant_lsb    LSB command granted this edge
//   grant_ic     fetch command granted this edge
//   flush_done   a flushed transaction retires this edge
//   force_fetch  fetch must win the next arbitration
module mem_arbiter_starve
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  input  logic ic_req,
  input  logic grant_lsb,
  input  logic grant_ic,
  input  logic flush_done,
  output logic force_fetch
);

  localparam logic [CNT_W-1:0] Limit = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] count;

  // Saturate at the limit so a store granted during a flush cannot push
  // the counter past the force threshold and wrap around.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (rdy) begin
      if (grant_ic || !ic_req || flush_done) begin
        count <= '0;
      end else if (grant_lsb && (count != Limit)) begin
        count <= count + CNT_W'(1);
      end
    end
  end

  assign force_fetch = (ic_req == Valid) && (count == Limit);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Sequencing arbiter between the instruction-cache fetch port and the
// load/store buffer port in front of a byte-serial memory controller.
// Grants one transaction at a time, holds the command until the controller
// completes, then routes the result to the owner. A flush (clear) drains an
// in-flight fetch or load silently but lets an in-flight store finish.
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to enable the fetch
// starvation guard; otherwise the LSB has strict priority over fetch.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   rdy                       global ready; low freezes all state
//   clear                     pipeline flush
//   ic_req/ic_addr            fetch request and address
//   ic_done/ic_data           fetch completion pulse and data
//   lsb_req/we/addr/len/wdata load/store request
//   lsb_done/lsb_rdata        load/store completion pulse and load data
//   mc_valid/we/addr/len/wdata command to the memory controller
//   mc_done/mc_rdata          controller completion pulse and read data
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int LEN_W        = 3,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_done,
  output logic [DATA_W-1:0] ic_data,
  input  logic              lsb_req,
  input  logic              lsb_we,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [LEN_W-1:0]  lsb_len,
  input  logic [DATA_W-1:0] lsb_wdata,
  output logic              lsb_done,
  output logic [DATA_W-1:0] lsb_rdata,
  output logic              mc_valid,
  output logic              mc_we,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [LEN_W-1:0]  mc_len,
  output logic [DATA_W-1:0] mc_wdata,
  input  logic              mc_done,
  input  logic [DATA_W-1:0] mc_rdata
);

  localparam logic [LEN_W-1:0] FetchLen = LEN_W'(4);

  arb_state_t state;
  logic       grant_lsb;
  logic       grant_ic;
  logic       cancel;
  logic       force_fetch;

  // During a flush only a store may be granted from idle; loads and fetches
  // belong to the squashed path. Otherwise LSB wins unless the guard forces
  // the fetch.
  always_comb begin
    grant_lsb = 1'b0;
    grant_ic  = 1'b0;
    if (state == ArbIdle) begin
      if (clear) begin
        grant_lsb = lsb_req && (lsb_we == Write);
      end else if (lsb_req && !force_fetch) begin
        grant_lsb = 1'b1;
      end else begin
        grant_ic = ic_req;
      end
    end
  end

  // A flush cancels anything in flight except a store.
  assign cancel = clear &&
                  ((state == ArbBusyI) || ((state == ArbBusyL) && (mc_we == Read)));

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic flush_done;

  assign flush_done = mc_done && ((state == ArbDrain) || cancel);

  mem_arbiter_starve #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_starve (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .ic_req      (ic_req),
    .grant_lsb   (grant_lsb),
    .grant_ic    (grant_ic),
    .flush_done  (flush_done),
    .force_fetch (force_fetch)
  );
`else
  logic [CNT_W-1:0] starve_cfg_unused;

  assign starve_cfg_unused = CNT_W'(STARVE_LIMIT);
  assign force_fetch       = 1'b0;
`endif

  // Main sequencer. The command registers are only loaded on a grant, so
  // they naturally hold steady until completion; on completion only
  // mc_valid drops. A simultaneous clear and mc_done retires the
  // transaction without delivering its result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ArbIdle;
      mc_valid  <= Invalid;
      mc_we     <= Read;
      mc_addr   <= '0;
      mc_len    <= '0;
      mc_wdata  <= '0;
      ic_done   <= 1'b0;
      ic_data   <= '0;
      lsb_done  <= 1'b0;
      lsb_rdata <= '0;
    end else if (!rdy) begin
      ic_done  <= 1'b0;
      lsb_done <= 1'b0;
    end else begin
      ic_done  <= 1'b0;
      lsb_done <= 1'b0;
      case (state)
        ArbIdle: begin
          if (grant_lsb) begin
            state    <= ArbBusyL;
            mc_valid <= Valid;
            mc_we    <= lsb_we;
            mc_addr  <= lsb_addr;
            mc_len   <= lsb_len;
            mc_wdata <= lsb_wdata;
          end else if (grant_ic) begin
            state    <= ArbBusyI;
            mc_valid <= Valid;
            mc_we    <= Read;
            mc_addr  <= ic_addr;
            mc_len   <= FetchLen;
            mc_wdata <= '0;
          end
        end
        ArbBusyI, ArbBusyL: begin
          if (cancel) begin
            if (mc_done) begin
              state    <= ArbIdle;
              mc_valid <= Invalid;
            end else begin
              state <= ArbDrain;
            end
          end else if (mc_done) begin
            state    <= ArbIdle;
            mc_valid <= Invalid;
            if (state == ArbBusyI) begin
              ic_done <= 1'b1;
              ic_data <= mc_rdata;
            end else begin
              lsb_done  <= 1'b1;
              lsb_rdata <= (mc_we == Write) ? '0 : mc_rdata;
            end
          end
        end
        ArbDrain: begin
          if (mc_done) begin
            state    <= ArbIdle;
            mc_valid <= Invalid;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: table-driven single transactions,
// hand-written multi-cycle sequences (reset, fetch, priority, starvation,
// flush, stall) and a randomized run against a transaction-level model.
// Honours MEM_ARB_STARVE_GUARD_EN the same way as the design.
module tb_mem_arbiter;

  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int LEN_W        = 3;
  localparam int STARVE_LIMIT = 4;
  localparam int CNT_W        = 3;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit StarveEn = 1'b1;
`else
  localparam bit StarveEn = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              rdy;
  logic              clear;
  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic              ic_done;
  logic [DATA_W-1:0] ic_data;
  logic              lsb_req;
  logic              lsb_we;
  logic [ADDR_W-1:0] lsb_addr;
  logic [LEN_W-1:0]  lsb_len;
  logic [DATA_W-1:0] lsb_wdata;
  logic              lsb_done;
  logic [DATA_W-1:0] lsb_rdata;
  logic              mc_valid;
  logic              mc_we;
  logic [ADDR_W-1:0] mc_addr;
  logic [LEN_W-1:0]  mc_len;
  logic [DATA_W-1:0] mc_wdata;
  logic              mc_done;
  logic [DATA_W-1:0] mc_rdata;

  mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
    .STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_data(ic_data),
    .lsb_req(lsb_req), .lsb_we(lsb_we), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
    .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
    .mc_valid(mc_valid), .mc_we(mc_we), .mc_addr(mc_addr), .mc_len(mc_len),
    .mc_wdata(mc_wdata), .mc_done(mc_done), .mc_rdata(mc_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // One table record: a request pattern from idle, the controller reply,
  // and the command and result the arbiter must produce.
  typedef struct {
    bit          ic_req;
    logic [31:0] ic_addr;
    bit          lsb_req;
    bit          lsb_we;
    logic [31:0] lsb_addr;
    logic [2:0]  lsb_len;
    logic [31:0] lsb_wdata;
    logic [31:0] rdata;
    bit          exp_lsb;
    bit          exp_we;
    logic [31:0] exp_addr;
    logic [2:0]  exp_len;
    logic [31:0] exp_wdata;
    logic [31:0] exp_result;
  } vec_t;

  vec_t vecs[7];

  // Transaction-level reference model state.
  bit          m_busy, m_lsb, m_flushed;
  int          m_starve;
  bit          e_valid, e_we, e_ic_done, e_lsb_done;
  logic [31:0] e_addr, e_wdata, e_ic_data, e_lsb_rdata;
  logic [2:0]  e_len;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    rdy = 1'b1; clear = 1'b0;
    ic_req = 1'b0; ic_addr = '0;
    lsb_req = 1'b0; lsb_we = 1'b0; lsb_addr = '0; lsb_len = '0; lsb_wdata = '0;
    mc_done = 1'b0; mc_rdata = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    ic_req    = v.ic_req;
    ic_addr   = v.ic_addr;
    lsb_req   = v.lsb_req;
    lsb_we    = v.lsb_we;
    lsb_addr  = v.lsb_addr;
    lsb_len   = v.lsb_len;
    lsb_wdata = v.lsb_wdata;
  endtask

  task automatic modelReset();
    m_busy = 0; m_lsb = 0; m_flushed = 0; m_starve = 0;
    e_valid = 0; e_we = 0; e_ic_done = 0; e_lsb_done = 0;
    e_addr = '0; e_wdata = '0; e_ic_data = '0; e_lsb_rdata = '0; e_len = '0;
  endtask

  // Predicts the outputs after the coming edge from the inputs now driven.
  task automatic modelStep();
    bit force_fetch, take_lsb, take_ic;
    e_ic_done  = 0;
    e_lsb_done = 0;
    if (!rdy) return;
    if (!m_busy) begin
      force_fetch = StarveEn && ic_req && (m_starve == STARVE_LIMIT);
      take_lsb    = lsb_req && (clear ? lsb_we : !force_fetch);
      take_ic     = !take_lsb && ic_req && !clear;
      if (take_lsb) begin
        m_busy = 1; m_lsb = 1; m_flushed = 0; e_valid = 1;
        e_we = lsb_we; e_addr = lsb_addr; e_len = lsb_len; e_wdata = lsb_wdata;
      end else if (take_ic) begin
        m_busy = 1; m_lsb = 0; m_flushed = 0; e_valid = 1;
        e_we = 0; e_addr = ic_addr; e_len = 3'd4; e_wdata = '0;
      end
      if (take_ic || !ic_req) m_starve = 0;
      else if (take_lsb && m_starve < STARVE_LIMIT) m_starve++;
    end else begin
      if (clear && !(m_lsb && e_we)) m_flushed = 1;
      if (mc_done) begin
        m_busy = 0; e_valid = 0;
        if (m_flushed) m_starve = 0;
        else if (m_lsb) begin
          e_lsb_done = 1; e_lsb_rdata = e_we ? 32'h0 : mc_rdata;
        end else begin
          e_ic_done = 1; e_ic_data = mc_rdata;
        end
      end
      if (!ic_req) m_starve = 0;
    end
  endtask

  initial begin
    bit exp_fetch;
    int lat;

    idleInputs();
    rst = 1'b1;

    vecs[0] = '{1, 32'h0000_2000, 0, 0, 32'h0,         3'd0, 32'h0,         32'h1111_2222,
                0, 0, 32'h0000_2000, 3'd4, 32'h0,         32'h1111_2222};
    vecs[1] = '{0, 32'h0,         1, 0, 32'h0000_2010, 3'd4, 32'h0000_0055, 32'h89AB_CDEF,
                1, 0, 32'h0000_2010, 3'd4, 32'h0000_0055, 32'h89AB_CDEF};
    vecs[2] = '{0, 32'h0,         1, 1, 32'h0000_2020, 3'd4, 32'hA5A5_5A5A, 32'hFFFF_FFFF,
                1, 1, 32'h0000_2020, 3'd4, 32'hA5A5_5A5A, 32'h0};
    vecs[3] = '{1, 32'h0000_7000, 1, 0, 32'h0000_2030, 3'd1, 32'h0,         32'h0000_00EE,
                1, 0, 32'h0000_2030, 3'd1, 32'h0,         32'h0000_00EE};
    vecs[4] = '{1, 32'h0000_7004, 1, 1, 32'h0000_2040, 3'd2, 32'h0000_BEEF, 32'h1234_5678,
                1, 1, 32'h0000_2040, 3'd2, 32'h0000_BEEF, 32'h0};
    vecs[5] = '{0, 32'h0,         1, 0, 32'h0000_2051, 3'd3, 32'h0,         32'h0012_3456,
                1, 0, 32'h0000_2051, 3'd3, 32'h0,         32'h0012_3456};
    vecs[6] = '{1, 32'hFFFF_FFFC, 0, 0, 32'h0,         3'd0, 32'h0,         32'hDEAD_0000,
                0, 0, 32'hFFFF_FFFC, 3'd4, 32'h0,         32'hDEAD_0000};

    // Reset held for two edges with a fetch pending.
    ic_req = 1'b1; ic_addr = 32'h0;
    cycle();
    cycle();
    checkOutput("rst_mc_valid",  32'(mc_valid),  32'h0);
    checkOutput("rst_mc_we",     32'(mc_we),     32'h0);
    checkOutput("rst_mc_addr",   mc_addr,        32'h0);
    checkOutput("rst_mc_len",    32'(mc_len),    32'h0);
    checkOutput("rst_mc_wdata",  mc_wdata,       32'h0);
    checkOutput("rst_ic_done",   32'(ic_done),   32'h0);
    checkOutput("rst_ic_data",   ic_data,        32'h0);
    checkOutput("rst_lsb_done",  32'(lsb_done),  32'h0);
    checkOutput("rst_lsb_rdata", lsb_rdata,      32'h0);
    rst = 1'b0;
    cycle();
    checkOutput("rst_rel_valid", 32'(mc_valid), 32'h1);
    checkOutput("rst_rel_addr",  mc_addr,       32'h0);
    checkOutput("rst_rel_len",   32'(mc_len),   32'h4);
    mc_done = 1'b1; mc_rdata = 32'hCAFE_0001;
    cycle();
    checkOutput("rst_rel_ic_done", 32'(ic_done), 32'h1);
    idleInputs();
    cycle();

    // Plain fetch with a five-cycle controller.
    ic_req = 1'b1; ic_addr = 32'h0000_1000;
    cycle();
    checkOutput("fetch_valid", 32'(mc_valid), 32'h1);
    checkOutput("fetch_addr",  mc_addr,       32'h0000_1000);
    checkOutput("fetch_len",   32'(mc_len),   32'h4);
    checkOutput("fetch_we",    32'(mc_we),    32'h0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      checkOutput("fetch_wait_done", 32'(ic_done), 32'h0);
      checkOutput("fetch_hold_addr", mc_addr,      32'h0000_1000);
    end
    mc_done = 1'b1; mc_rdata = 32'h00A0_0093;
    cycle();
    checkOutput("fetch_done",      32'(ic_done),  32'h1);
    checkOutput("fetch_data",      ic_data,       32'h00A0_0093);
    checkOutput("fetch_end_valid", 32'(mc_valid), 32'h0);
    idleInputs();
    cycle();
    checkOutput("fetch_single_pulse", 32'(ic_done),  32'h0);
    checkOutput("fetch_idle_valid",   32'(mc_valid), 32'h0);

    // Table-driven single transactions from idle.
    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v]);
      cycle();
      checkOutput($sformatf("vec%0d_valid", v), 32'(mc_valid), 32'h1);
      checkOutput($sformatf("vec%0d_we", v),    32'(mc_we),    32'(vecs[v].exp_we));
      checkOutput($sformatf("vec%0d_addr", v),  mc_addr,       vecs[v].exp_addr);
      checkOutput($sformatf("vec%0d_len", v),   32'(mc_len),   32'(vecs[v].exp_len));
      checkOutput($sformatf("vec%0d_wdata", v), mc_wdata,      vecs[v].exp_wdata);
      mc_done = 1'b1; mc_rdata = vecs[v].rdata;
      cycle();
      checkOutput($sformatf("vec%0d_ic_done", v),  32'(ic_done),  32'(!vecs[v].exp_lsb));
      checkOutput($sformatf("vec%0d_lsb_done", v), 32'(lsb_done), 32'(vecs[v].exp_lsb));
      checkOutput($sformatf("vec%0d_result", v),
                  vecs[v].exp_lsb ? lsb_rdata : ic_data, vecs[v].exp_result);
      checkOutput($sformatf("vec%0d_end_valid", v), 32'(mc_valid), 32'h0);
      idleInputs();
      cycle();
    end

    // Simultaneous requests: load first, fetch afterwards.
    ic_req = 1'b1; ic_addr = 32'h0000_1100;
    lsb_req = 1'b1; lsb_we = 1'b0; lsb_addr = 32'h0000_2004; lsb_len = 3'd2;
    cycle();
    checkOutput("prio_first_addr", mc_addr,     32'h0000_2004);
    checkOutput("prio_first_len",  32'(mc_len), 32'h2);
    mc_done = 1'b1; mc_rdata = 32'h0000_BEEF;
    cycle();
    checkOutput("prio_lsb_done",  32'(lsb_done), 32'h1);
    checkOutput("prio_lsb_rdata", lsb_rdata,     32'h0000_BEEF);
    checkOutput("prio_no_ic",     32'(ic_done),  32'h0);
    lsb_req = 1'b0; mc_done = 1'b0;
    cycle();
    checkOutput("prio_second_addr", mc_addr,     32'h0000_1100);
    checkOutput("prio_second_len",  32'(mc_len), 32'h4);
    mc_done = 1'b1; mc_rdata = 32'h0000_0013;
    cycle();
    checkOutput("prio_ic_done", 32'(ic_done), 32'h1);
    idleInputs();
    cycle();

    // Both requesters held: the guard forces the fetch on the fifth grant.
    ic_req = 1'b1; ic_addr = 32'h0000_6000;
    lsb_req = 1'b1; lsb_we = 1'b0; lsb_len = 3'd4;
    for (int k = 0; k < 5; k++) begin
      lsb_addr = 32'h0000_4000 + 32'(k * 4);
      cycle();
      exp_fetch = StarveEn && (k == 4);
      checkOutput($sformatf("starve_grant%0d", k), mc_addr,
                  exp_fetch ? 32'h0000_6000 : lsb_addr);
      mc_done = 1'b1; mc_rdata = 32'h100 + 32'(k);
      cycle();
      checkOutput($sformatf("starve_ic_done%0d", k),  32'(ic_done),  32'(exp_fetch));
      checkOutput($sformatf("starve_lsb_done%0d", k), 32'(lsb_done), 32'(!exp_fetch));
      mc_done = 1'b0;
      if (exp_fetch) ic_req = 1'b0;
    end
    lsb_req = 1'b0;
    if (ic_req) begin
      cycle();
      checkOutput("starve_late_fetch", mc_addr, 32'h0000_6000);
      mc_done = 1'b1;
      cycle();
      checkOutput("starve_late_done", 32'(ic_done), 32'h1);
    end
    idleInputs();
    cycle();

    // Flush during a load: no result, back to idle, stray mc_done ignored.
    lsb_req = 1'b1; lsb_we = 1'b0; lsb_addr = 32'h0000_3000; lsb_len = 3'd4;
    cycle();
    clear = 1'b1; lsb_req = 1'b0;
    cycle();
    clear = 1'b0;
    checkOutput("flushld_hold_valid", 32'(mc_valid), 32'h1);
    checkOutput("flushld_hold_addr",  mc_addr,       32'h0000_3000);
    cycle();
    mc_done = 1'b1; mc_rdata = 32'h0BAD_0BAD;
    cycle();
    checkOutput("flushld_no_done", 32'(lsb_done), 32'h0);
    checkOutput("flushld_valid",   32'(mc_valid), 32'h0);
    cycle();
    checkOutput("idle_mcdone_lsb", 32'(lsb_done), 32'h0);
    checkOutput("idle_mcdone_ic",  32'(ic_done),  32'h0);
    checkOutput("idle_mcdone_vld", 32'(mc_valid), 32'h0);
    idleInputs();
    cycle();

    // Flush during a store: the store still completes.
    lsb_req = 1'b1; lsb_we = 1'b1; lsb_addr = 32'h0000_3000;
    lsb_len = 3'd4; lsb_wdata = 32'hDEAD_BEEF;
    cycle();
    checkOutput("flushst_we",    32'(mc_we), 32'h1);
    checkOutput("flushst_wdata", mc_wdata,   32'hDEAD_BEEF);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    checkOutput("flushst_valid", 32'(mc_valid), 32'h1);
    mc_done = 1'b1; mc_rdata = 32'h1234_5678;
    cycle();
    checkOutput("flushst_done",  32'(lsb_done), 32'h1);
    checkOutput("flushst_rdata", lsb_rdata,     32'h0);
    idleInputs();
    cycle();

    // Stall with mc_done waiting: pulse only once rdy returns.
    ic_req = 1'b1; ic_addr = 32'h0000_5000;
    cycle();
    mc_done = 1'b1; mc_rdata = 32'h1122_3344; rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checkOutput("stall_no_done", 32'(ic_done),  32'h0);
      checkOutput("stall_valid",   32'(mc_valid), 32'h1);
      checkOutput("stall_addr",    mc_addr,       32'h0000_5000);
      checkOutput("stall_len",     32'(mc_len),   32'h4);
    end
    rdy = 1'b1;
    cycle();
    checkOutput("stall_done", 32'(ic_done), 32'h1);
    checkOutput("stall_data", ic_data,      32'h1122_3344);
    idleInputs();
    cycle();

    // Randomized traffic against the reference model.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    modelReset();
    lat = 0;
    for (int c = 0; c < 1500; c++) begin
      if (mc_done) begin
        if (rdy) mc_done = 1'b0;
      end else if (mc_valid) begin
        if (lat == 0) begin
          mc_done = 1'b1; mc_rdata = $urandom;
        end else begin
          lat--;
        end
      end else begin
        lat = $urandom_range(0, 4);
        if ($urandom_range(0, 19) == 0) begin
          mc_done = 1'b1; mc_rdata = $urandom;
        end
      end
      if (ic_done) ic_req = 1'b0;
      else if (!ic_req && $urandom_range(0, 2) == 0) begin
        ic_req = 1'b1; ic_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (lsb_done) lsb_req = 1'b0;
      else if (!lsb_req && $urandom_range(0, 1) == 0) begin
        lsb_req = 1'b1; lsb_we = 1'($urandom_range(0, 1));
        lsb_addr = $urandom; lsb_wdata = $urandom;
        case ($urandom_range(0, 3))
          0: lsb_len = 3'd1;
          1: lsb_len = 3'd2;
          2: lsb_len = 3'd4;
          default: lsb_len = 3'd3;
        endcase
      end
      clear = ($urandom_range(0, 11) == 0);
      if (clear) begin
        ic_req = 1'b0;
        if (!lsb_we) lsb_req = 1'b0;
      end
      rdy = ($urandom_range(0, 7) != 0);
      modelStep();
      cycle();
      checkOutput("rnd_mc_valid",  32'(mc_valid),  32'(e_valid));
      checkOutput("rnd_mc_we",     32'(mc_we),     32'(e_we));
      checkOutput("rnd_mc_addr",   mc_addr,        e_addr);
      checkOutput("rnd_mc_len",    32'(mc_len),    32'(e_len));
      checkOutput("rnd_mc_wdata",  mc_wdata,       e_wdata);
      checkOutput("rnd_ic_done",   32'(ic_done),   32'(e_ic_done));
      checkOutput("rnd_ic_data",   ic_data,        e_ic_data);
      checkOutput("rnd_lsb_done",  32'(lsb_done),  32'(e_lsb_done));
      checkOutput("rnd_lsb_rdata", lsb_rdata,      e_lsb_rdata);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
